fighter_sprite_addr_gen: RTL

FIGHTER_SPRITE_ADDR_GEN -- requirements
Module: fighter_sprite_addr_gen

---
 rtl/fighter_pkg.sv | 18 +
 rtl/anim_frame_counter.sv | 79 +++++++
 rtl/fighter_sprite_addr_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Purpose: shared types and default geometry for the fighter sprite address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: anim_state_t animation state enum and the default hitbox, sprite and animation sizes.
package fighter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1
  } anim_state_t;

  localparam int HITBOX_W   = 80;
  localparam int HITBOX_H   = 160;
  localparam int SPR_W      = 60;
  localparam int SPR_H      = 90;
  localparam int NUM_FRAMES = 6;

endpackage

// File: rtl/anim_frame_counter.sv
// Purpose: walk-animation state machine with a per-step tick divider and frame index.
// Latency: state/frame update on the frame_tick edge; outputs are registers.
// Backpressure: none; frame_tick_i is a single-cycle pulse that is never stalled.
// Ports: vga_clk_i/reset_i (sync, active-high), frame_tick_i, walk_req_i,
//        anim_state_o (IDLE/WALK), frame_sel_o (0..NUM_FRAMES-1).
module anim_frame_counter
  import fighter_pkg::*;
#(
  parameter int NUM_FRAMES      = fighter_pkg::NUM_FRAMES,
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic        vga_clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic        walk_req_i,
  output anim_state_t anim_state_o,
  output logic [2:0]  frame_sel_o
);

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  anim_state_t   state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    frame_sel_q, frame_sel_d;

  always_ff @(posedge vga_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      frame_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      frame_sel_q <= frame_sel_d;
    end
  end

  // Everything holds between ticks so a frame is never torn mid-scan.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    frame_sel_d = frame_sel_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_i && walk_req_i) begin
          state_d     = WALK;
          tick_cnt_d  = '0;
          frame_sel_d = '0;
        end
      end
      WALK: begin
        if (frame_tick_i) begin
          if (walk_req_i) begin
            if (tick_cnt_q == TW'(TICKS_PER_FRAME - 1)) begin
              tick_cnt_d  = '0;
              frame_sel_d = (frame_sel_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_sel_q + 3'd1;
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end else begin
            state_d     = IDLE;
            tick_cnt_d  = '0;
            frame_sel_d = '0;
          end
        end
      end
      // Unused encodings fall back to a clean IDLE immediately.
      default: begin
        state_d     = IDLE;
        tick_cnt_d  = '0;
        frame_sel_d = '0;
      end
    endcase
  end

  assign anim_state_o = state_q;
  assign frame_sel_o  = frame_sel_q;

endmodule

// File: rtl/fighter_sprite_addr_gen.sv
// Purpose: maps the scan position onto a scaled (optionally mirrored) sprite ROM address.
// Latency: rom_address/in_sprite one vga_clk after DrawX/DrawY; animation updates on frame_tick.
// Backpressure: none; free-running pixel pipeline.
// Ports: vga_clk, reset (sync, active-high), DrawX/DrawY/blank scan inputs, frame_tick,
//        pos_x/pos_y hitbox origin, walk_req, facing_left; outputs rom_address, frame_sel,
//        in_sprite, anim_state.
// Build option: define FIGHTER_MIRROR_EN to enable horizontal mirroring from facing_left.
module fighter_sprite_addr_gen
  import fighter_pkg::*;
#(
  parameter int HITBOX_W        = fighter_pkg::HITBOX_W,
  parameter int HITBOX_H        = fighter_pkg::HITBOX_H,
  parameter int SPR_W           = fighter_pkg::SPR_W,
  parameter int SPR_H           = fighter_pkg::SPR_H,
  parameter int NUM_FRAMES      = fighter_pkg::NUM_FRAMES,
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        frame_tick,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        walk_req,
  input  logic        facing_left,
  output logic [12:0] rom_address,
  output logic [2:0]  frame_sel,
  output logic        in_sprite,
  output logic [1:0]  anim_state
);

  anim_state_t state_w;

  anim_frame_counter #(
    .NUM_FRAMES      (NUM_FRAMES),
    .TICKS_PER_FRAME (TICKS_PER_FRAME)
  ) u_anim (
    .vga_clk_i    (vga_clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .walk_req_i   (walk_req),
    .anim_state_o (state_w),
    .frame_sel_o  (frame_sel)
  );

  assign anim_state = state_w;

  // 11-bit arithmetic so a hitbox near column/row 1023 does not wrap.
  logic [10:0] lx, ly, x_end, y_end;
  logic        hit;
  logic [16:0] col, row, col_sel;

  assign lx    = {1'b0, DrawX} - {1'b0, pos_x};
  assign ly    = {1'b0, DrawY} - {1'b0, pos_y};
  assign x_end = {1'b0, pos_x} + 11'(HITBOX_W);
  assign y_end = {1'b0, pos_y} + 11'(HITBOX_H);

  assign hit = blank && (DrawX >= pos_x) && ({1'b0, DrawX} < x_end)
                     && (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);

  // Scale hitbox-relative offsets down to sprite texels; division truncates.
  assign col = (17'(lx) * 17'(SPR_W)) / 17'(HITBOX_W);
  assign row = (17'(ly) * 17'(SPR_H)) / 17'(HITBOX_H);

`ifdef FIGHTER_MIRROR_EN
  // Latched only on frame_tick so a whole video frame shares one orientation.
  logic mirror_q, mirror_d;

  always_comb begin
    mirror_d = mirror_q;
    if (frame_tick) mirror_d = facing_left;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) mirror_q <= 1'b0;
    else       mirror_q <= mirror_d;
  end

  assign col_sel = mirror_q ? (17'(SPR_W - 1) - col) : col;
`else
  logic unused_facing_left;
  assign unused_facing_left = facing_left;
  assign col_sel = col;
`endif

  logic [12:0] rom_address_q, rom_address_d;
  logic        in_sprite_q, in_sprite_d;

  always_comb begin
    rom_address_d = '0;
    in_sprite_d   = 1'b0;
    if (hit) begin
      rom_address_d = 13'(col_sel + row * 17'(SPR_W));
      in_sprite_d   = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address_q <= '0;
      in_sprite_q   <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      in_sprite_q   <= in_sprite_d;
    end
  end

  assign rom_address = rom_address_q;
  assign in_sprite   = in_sprite_q;

endmodule
